// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the ALU opcode space and the multiplier sequencer states.
package alu_mul_seq_pkg;

  localparam int unsigned ALU_W  = 32;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake of the multiplier plus its private port onto the shared ALU.
interface alu_mul_seq_if
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
);

  logic                start;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    product;
  logic                zero;

  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [WIDTH-1:0]    alu_f;
  logic                alu_of;

  // Host issuing multiply requests
  modport master (
    output start, op_a, op_b,
    input  busy, done, product, zero
  );

  // The multiplier sequencer
  modport slave (
    input  start, op_a, op_b, alu_f, alu_of,
    output busy, done, product, zero, alu_a, alu_b, alu_op
  );

  // The shared combinational ALU
  modport alu (
    input  alu_a, alu_b, alu_op,
    output alu_f, alu_of
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the shared ALU for its adds and shifts;
// yields the low WIDTH bits of the unsigned product op_a*op_b.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  alu_mul_seq_if.slave  bus
);

  mul_state_e          state, state_n;
  logic [WIDTH-1:0]    acc, acc_n;
  logic [WIDTH-1:0]    mcand, mcand_n;
  logic [WIDTH-1:0]    mplier, mplier_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0]    product_q, product_n;
  logic                zero_q, zero_n;
  logic                busy_q, done_q;
  logic [WIDTH-1:0]    alu_a_c, alu_b_c;
  logic [ALU_OP_W-1:0] alu_op_c;
  logic                unused_alu_of;

  // Overflow is meaningless for a truncated unsigned product
  assign unused_alu_of = bus.alu_of;

  // Next-state, datapath updates and ALU drive
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    cnt_n     = cnt;
    product_n = product_q;
    zero_n    = zero_q;
    alu_a_c   = acc;
    alu_b_c   = mcand;
    alu_op_c  = ALU_ADD;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          mcand_n  = bus.op_a;
          mplier_n = bus.op_b;
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = S_ADD;
        end
      end
      S_ADD: begin
        // Stops early once the remaining multiplier bits are all zero
        if (mplier == '0 || cnt == CNT_W'(WIDTH)) begin
          state_n = S_DONE;
        end else begin
          if (mplier[0]) acc_n = bus.alu_f;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        alu_a_c  = WIDTH'(1);
        alu_op_c = ALU_SLL;
        mcand_n  = bus.alu_f;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CNT_W'(1);
        state_n  = S_ADD;
      end
      S_DONE: begin
        product_n = acc;
        zero_n    = (acc == '0);
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; busy/done are registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      cnt       <= cnt_n;
      product_q <= product_n;
      zero_q    <= zero_n;
      busy_q    <= (state_n != S_IDLE);
      done_q    <= (state_n == S_DONE);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.zero    = zero_q;
  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;
  assign bus.alu_op  = alu_op_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: closes the loop through a behavioural ALU and checks
// every cycle against a transaction-level model (product = a*b mod 2^32).
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alu_mul_seq_if #(.WIDTH(W)) bus ();

  alu_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural shared ALU
  logic [W-1:0] alu_res;
  logic         alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    case (bus.alu_op)
      ALU_AND: alu_res = bus.alu_a & bus.alu_b;
      ALU_OR:  alu_res = bus.alu_a | bus.alu_b;
      ALU_XOR: alu_res = bus.alu_a ^ bus.alu_b;
      ALU_NOR: alu_res = ~(bus.alu_a | bus.alu_b);
      ALU_ADD: begin
        alu_res = bus.alu_a + bus.alu_b;
        alu_ovf = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_res[W-1] != bus.alu_a[W-1]);
      end
      ALU_SUB: alu_res = bus.alu_a - bus.alu_b;
      ALU_SLT: alu_res = W'($signed(bus.alu_a) < $signed(bus.alu_b));
      ALU_SLL: alu_res = bus.alu_b << bus.alu_a[4:0];
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_f  = alu_res;
  assign bus.alu_of = alu_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return p[W-1:0];
  endfunction

  // Transaction model: clock period n follows edge n
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_done = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_prod = '0;
  bit           m_zero = 1'b1;
  bit           sll_seen = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_prod   = '0;
      m_zero   = 1'b1;
    end else if (m_active && cyc == m_done + 1) begin
      m_prod   = m_pend;
      m_zero   = (m_pend == '0);
      m_active = 1'b0;
    end else if (!m_active && bus.start) begin
      m_active = 1'b1;
      m_done   = cyc + 2 * bitlen(bus.op_b) + 1;
      m_pend   = ref_prod(bus.op_a, bus.op_b);
    end
    #1;
    chk("busy", W'(bus.busy), W'(m_active));
    chk("done", W'(bus.done), W'(m_active && cyc == m_done));
    chk("product", bus.product, m_prod);
    chk("zero", W'(bus.zero), W'(m_zero));
    chk("alu_op_legal", W'(bus.alu_op == ALU_ADD || bus.alu_op == ALU_SLL), W'(1));
    if (bus.alu_op == ALU_SLL) sll_seen = 1'b1;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_p, input int exp_lat,
                        input bit scramble, input string nm);
    int lat = 0;
    @(negedge clock);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (scramble) begin
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
    end while (!bus.done && lat < 100);
    chk({nm, "_latency"}, W'(lat), W'(exp_lat));
    @(posedge clock); #1;
    chk({nm, "_product"}, bus.product, exp_p);
    chk({nm, "_zero"}, W'(bus.zero), W'(exp_p == '0));
  endtask

  initial begin
    int lat;
    int dones;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_product", bus.product, W'(0));
    chk("rst_zero", W'(bus.zero), W'(1));
    reset = 1'b0;

    run_op(32'h0000_0607, 32'd3, 32'h0000_1215, 6, 1'b0, "s1");

    sll_seen = 1'b0;
    run_op(32'h1234_5678, 32'd0, 32'h0, 2, 1'b0, "s2");
    chk("s2_no_sll", W'(sll_seen), W'(0));

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 66, 1'b0, "s3");
    run_op(32'h8000_0000, 32'd2, 32'h0, 6, 1'b0, "s4");

    // Extra start pulses while busy and during DONE are dropped
    @(negedge clock);
    bus.op_a = 32'h607; bus.op_b = 32'd3; bus.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (i == 3 || i == 6) begin
        bus.start = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd9;
      end
      if (i == 6) chk("s5_done", W'(bus.done), W'(1));
      if (i == 7) chk("s5_idle_after_done", W'(bus.busy), W'(0));
    end
    chk("s5_product", bus.product, 32'h0000_1215);

    // Reset mid-operation aborts without a done pulse
    @(negedge clock);
    bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("s6_busy", W'(bus.busy), W'(0));
    chk("s6_product", bus.product, W'(0));
    chk("s6_zero", W'(bus.zero), W'(1));
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("s6_no_done", W'(bus.done), W'(0));
    end
    run_op(32'd5, 32'd7, 32'h0000_0023, 8, 1'b0, "s6b");

    // Start coincident with reset is not accepted
    @(negedge clock);
    reset = 1'b1; bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd3;
    @(posedge clock); #1;
    chk("rst_vs_start_busy", W'(bus.busy), W'(0));
    @(negedge clock);
    reset = 1'b0; bus.start = 1'b0;

    // Start held high: back-to-back operations with one IDLE cycle between
    @(negedge clock);
    bus.op_a = 32'd3; bus.op_b = 32'd5; bus.start = 1'b1;
    dones = 0; lat = 0;
    while (dones < 2 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    chk("held_two_ops", W'(dones), W'(2));
    chk("held_cycles", W'(lat), W'(17));
    chk("held_product_pending", bus.product, 32'h0000_000F);
    lat = 0;
    while (bus.busy && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("held_idle", W'(bus.busy), W'(0));
    chk("held_product", bus.product, 32'h0000_000F);

    // Randomized operands, operand churn while busy, random idle gaps
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (k % 10 == 0) rb = '0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_op(ra, rb, ref_prod(ra, rb), 2 * bitlen(rb) + 2, 1'b1, "rand");
    end

    repeat (2) @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
